// File: rtl/timer_responder.sv
// -----------------------------------------------------------------------------
// timer_responder
//
// Memory-mapped countdown timer that sits on the CPU data bus as a responder.
// The 16-byte register window at BASE_ADDR is laid out as:
//   +0x0 CTRL   : bit0 EN, bits2:1 MODE, bit3 IM (upper bits read 0)
//   +0x4 PRESET : reload value, R/W
//   +0x8 COUNT  : current count, read-only
//   +0xC        : reads 0, writes ignored
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   reset  - asynchronous active-low reset
//   addr   - CPU data address
//   we     - write request for this cycle
//   byteen - per-byte write enables (bit i -> wdata[8i+7:8i])
//   wdata  - write data
//   rdata  - combinational read data (0 when addr is outside the window)
//   irq    - interrupt request, irq_flag gated by CTRL.IM
// -----------------------------------------------------------------------------
module timer_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_7F00,
  parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        hit;
  logic        wr_commit;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        ctrl_en;
  logic        mode_reload;
  logic [31:0] ctrl_merged;
  logic [31:0] preset_merged;

  // The low address bits are irrelevant to a word-wide register window.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // Overlay the enabled bytes of wdata on top of an existing word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_commit   = hit & we & (byteen != 4'b0000);
  assign wr_ctrl     = wr_commit & (addr[3:2] == 2'd0);
  assign wr_preset   = wr_commit & (addr[3:2] == 2'd1);
  assign ctrl_en     = ctrl_q[0];
  assign mode_reload = (ctrl_q[2:1] == 2'b01);

  // Read mux: purely combinational, no side effects.
  always_comb begin
    rdata = 32'h0;
    if (hit) begin
      case (addr[3:2])
        2'd0:    rdata = {28'h0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = 32'h0;
      endcase
    end
  end

  assign irq = irq_flag_q & ctrl_q[3];

  // Next-state: the FSM acts on current register values first, then any CPU
  // write is layered on top so a committed write always wins over the FSM.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      S_IDLE: begin
        if (ctrl_en) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_en) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // 0 or 1 both terminate here, so COUNT never wraps below zero.
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = S_INT;
        end
      end
      S_INT: begin
        state_d = S_IDLE;
        if (mode_reload) begin
          irq_flag_d = 1'b0;   // one-cycle pulse, EN kept for auto-reload
        end else begin
          ctrl_d[0] = 1'b0;    // one-shot: disable, flag stays until CTRL write
        end
      end
      default: state_d = S_IDLE;
    endcase

    ctrl_merged   = merge_bytes({28'h0, ctrl_d}, wdata, byteen);
    preset_merged = merge_bytes(preset_q, wdata, byteen);

    if (wr_ctrl) begin
      ctrl_d     = ctrl_merged[3:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = preset_merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 4'h0;
      preset_q   <= RESET_PRESET;
      count_q    <= 32'h0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

endmodule

// File: tb/tb_timer_responder.sv
module tb_timer_responder;

  localparam logic [31:0] BASE      = 32'h0000_7F00;
  localparam logic [31:0] RST_PRE   = 32'h0000_0007;
  localparam logic [31:0] A_CTRL    = BASE + 32'h0;
  localparam logic [31:0] A_PRESET  = BASE + 32'h4;
  localparam logic [31:0] A_COUNT   = BASE + 32'h8;
  localparam logic [31:0] A_RSVD    = BASE + 32'hC;
  localparam logic [31:0] A_MISS    = BASE + 32'h14;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks_cnt;
  int fail_cnt;

  timer_responder #(
    .BASE_ADDR    (BASE),
    .RESET_PRESET (RST_PRE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Drive a write on the falling edge; it commits on the following rising
  // edge. Returns 1ns after that edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr   = a;
    wdata  = d;
    byteen = be;
    we     = 1'b1;
    @(posedge clk);
    #1;
    we     = 1'b0;
    byteen = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check_eq(tag, v, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check_eq(tag, {31'h0, irq}, {31'h0, exp});
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    reset  = 1'b1;
    addr   = 32'h0;
    we     = 1'b0;
    byteen = 4'h0;
    wdata  = 32'h0;

    // ---------------- power-on reset ----------------
    #2 reset = 1'b0;
    #1;
    check_reg("por_ctrl",   A_CTRL,   32'h0);
    check_reg("por_preset", A_PRESET, RST_PRE);
    check_reg("por_count",  A_COUNT,  32'h0);
    check_irq("por_irq", 1'b0);
    step(2);
    @(negedge clk) reset = 1'b1;

    // ---------------- reset mid-count ----------------
    bus_write(A_PRESET, 32'd5, 4'hF);
    bus_write(A_CTRL, 32'h9, 4'hF);               // E0
    step(2);                                      // E2
    check_reg("mid_count5", A_COUNT, 32'd5);
    #1 reset = 1'b0;
    #1;
    check_reg("arst_ctrl",   A_CTRL,   32'h0);
    check_reg("arst_preset", A_PRESET, RST_PRE);
    check_reg("arst_count",  A_COUNT,  32'h0);
    check_irq("arst_irq", 1'b0);
    @(negedge clk) reset = 1'b1;
    step(4);
    check_reg("post_rst_count", A_COUNT, 32'h0);
    check_irq("post_rst_irq", 1'b0);

    // ---------------- byte enables / decode ----------------
    bus_write(A_PRESET, 32'h0, 4'hF);
    bus_write(A_PRESET, 32'hAABBCCDD, 4'b0101);
    check_reg("be_preset", A_PRESET, 32'h00BB00DD);
    bus_write(A_COUNT, 32'h1234, 4'hF);
    check_reg("wr_count_ign", A_COUNT, 32'h0);
    bus_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
    check_reg("rsvd_read", A_RSVD, 32'h0);
    bus_write(A_MISS, 32'hFFFF_FFFF, 4'hF);
    check_reg("miss_preset", A_PRESET, 32'h00BB00DD);
    bus_write(A_MISS - 32'h10, 32'h1, 4'hF);      // 0x7F04 aliased below window? no: 0x7F04 is PRESET
    check_reg("hit_preset", A_PRESET, 32'h1);
    bus_write(A_PRESET, 32'h55, 4'h0);
    check_reg("be0_preset", A_PRESET, 32'h1);
    bus_write(A_CTRL, 32'h9, 4'h0);
    check_reg("be0_ctrl", A_CTRL, 32'h0);
    check_reg("miss_rdata", A_MISS, 32'h0);

    // ---------------- one-shot ----------------
    bus_write(A_PRESET, 32'd3, 4'hF);
    bus_write(A_CTRL, 32'h9, 4'hF);               // E0
    step(2);                                      // E2
    check_reg("os_cnt_e2", A_COUNT, 32'd3);
    step(1);
    check_reg("os_cnt_e3", A_COUNT, 32'd2);
    step(1);
    check_reg("os_cnt_e4", A_COUNT, 32'd1);
    check_irq("os_irq_e4", 1'b0);
    step(1);
    check_reg("os_cnt_e5", A_COUNT, 32'd0);
    check_irq("os_irq_e5", 1'b1);
    step(1);
    check_reg("os_ctrl_e6", A_CTRL, 32'h8);
    check_irq("os_irq_e6", 1'b1);
    step(3);
    check_irq("os_irq_hold", 1'b1);
    check_reg("os_cnt_hold", A_COUNT, 32'd0);
    bus_write(A_CTRL, 32'h0, 4'hF);
    check_irq("os_irq_clr", 1'b0);

    // ---------------- auto-reload ----------------
    bus_write(A_PRESET, 32'd2, 4'hF);
    bus_write(A_CTRL, 32'hB, 4'hF);               // E0
    for (int k = 1; k <= 15; k++) begin
      step(1);
      check_irq($sformatf("ar_irq_e%0d", k), (k == 4) || (k == 9) || (k == 14));
    end
    check_reg("ar_ctrl", A_CTRL, 32'hB);
    bus_write(A_CTRL, 32'h0, 4'hF);
    step(4);
    check_irq("ar_stop_irq", 1'b0);

    // ---------------- interrupt masking ----------------
    bus_write(A_PRESET, 32'd1, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);               // E0, IM=0
    step(3);                                      // E3: INT, flag set
    check_reg("mask_cnt", A_COUNT, 32'd0);
    check_irq("mask_irq", 1'b0);
    step(1);                                      // E4: EN cleared
    check_reg("mask_ctrl", A_CTRL, 32'h0);
    bus_write(A_CTRL, 32'h0000_0008, 4'b0001);
    check_reg("mask_ctrl_im", A_CTRL, 32'h8);
    check_irq("mask_irq_after", 1'b0);
    step(2);
    check_irq("mask_irq_late", 1'b0);

    // ---------------- collision: CTRL write on INT->IDLE ----------------
    bus_write(A_PRESET, 32'd1, 4'hF);
    bus_write(A_CTRL, 32'h9, 4'hF);               // E0
    step(3);                                      // E3: INT
    check_irq("col_irq_e3", 1'b1);
    bus_write(A_CTRL, 32'h9, 4'hF);               // commits at E4
    check_reg("col_ctrl", A_CTRL, 32'h9);
    check_irq("col_irq_e4", 1'b0);
    step(2);                                      // E6: reloaded
    check_reg("col_reload_cnt", A_COUNT, 32'd1);
    step(1);                                      // E7: fires again
    check_irq("col_irq_e7", 1'b1);
    bus_write(A_CTRL, 32'h0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
